// File: rtl/counter_pkg.sv
// Shared definitions for the counter control/compare block.
//   - Word addresses of the four MMIO registers
//   - Bit positions inside CTRL and STATUS
//   - FSM state type
package counter_pkg;

    // Register word addresses
    localparam logic [1:0] CTRL_A   = 2'd0;
    localparam logic [1:0] CMP_A    = 2'd1;
    localparam logic [1:0] STATUS_A = 2'd2;
    localparam logic [1:0] COUNT_A  = 2'd3;

    // CTRL bit positions; CLR is write-only and not stored
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_AUTOCLR = 1;
    localparam int unsigned CTRL_IRQEN   = 2;
    localparam int unsigned CTRL_ONESHOT = 3;
    localparam int unsigned CTRL_CLR     = 4;

    // STATUS bit positions
    localparam int unsigned ST_MATCH = 0;
    localparam int unsigned ST_OVF   = 1;

    typedef enum logic [1:0] {IDLE, ARMED, FIRED} cnt_state_t;

endpackage

// File: rtl/counter_ctrl.sv
// Control and compare stage for the free-running cycle counter.
// Provides CTRL/CMP/STATUS/COUNT word registers over a simple MMIO strobe
// interface, compare-match detection with auto-reload and one-shot modes,
// a sticky MATCH flag and a level interrupt.
//
// Ports:
//   clk        system clock
//   Rst        synchronous active-low reset
//   addr       word select: 0 CTRL, 1 CMP, 2 STATUS, 3 COUNT
//   wr_en      single-cycle write strobe
//   rd_en      single-cycle read strobe
//   wdata      write data
//   rdata      read data, valid the cycle after rd_en, held otherwise
//   cnt_dout   current counter value
//   cnt_ovflw  counter overflow flag (held by the counter until cleared)
//   cnt_zero   registered synchronous clear pulse to the counter
//   irq        level interrupt = MATCH & IRQEN
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [CNT_W-1:0]  cnt_dout,
    input  logic              cnt_ovflw,
    output logic              cnt_zero,
    output logic              irq
);

    logic [CTRL_CLR-1:0] ctrl_q;
    logic [CNT_W-1:0]    cmp_q;
    logic                match_q;
    cnt_state_t          state_q;
    logic [31:0]         rdata_q;
    logic                cnt_zero_q;
    // Stretches the reset-driven clear into the first cycle after release
    logic                rst_hold_q;

    logic wr_ctrl, wr_cmp, wr_status;
    logic match_evt;
    logic zero_req;
    logic [31:0] rd_mux;

    assign wr_ctrl   = wr_en && (addr == ADDR_W'(CTRL_A));
    assign wr_cmp    = wr_en && (addr == ADDR_W'(CMP_A));
    assign wr_status = wr_en && (addr == ADDR_W'(STATUS_A));

    // Uses the registered CTRL/CMP, so a same-cycle write only affects later cycles
    assign match_evt = (state_q == ARMED) && (cnt_dout == cmp_q);

    // All clear sources merge into one pulse request
    assign zero_req = (wr_ctrl && wdata[CTRL_CLR])
                    | (wr_status && wdata[ST_OVF])
                    | (match_evt && ctrl_q[CTRL_AUTOCLR]);

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_W'(CTRL_A):   rd_mux = 32'(ctrl_q);
            ADDR_W'(CMP_A):    rd_mux = 32'(cmp_q);
            ADDR_W'(STATUS_A): rd_mux = {30'd0, cnt_ovflw, match_q};
            ADDR_W'(COUNT_A):  rd_mux = 32'(cnt_dout);
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            ctrl_q     <= '0;
            cmp_q      <= '1;
            match_q    <= 1'b0;
            state_q    <= IDLE;
            rdata_q    <= '0;
            cnt_zero_q <= 1'b1;
            rst_hold_q <= 1'b1;
        end else begin
            rst_hold_q <= 1'b0;
            cnt_zero_q <= rst_hold_q | zero_req;

            if (wr_ctrl) begin
                ctrl_q <= wdata[CTRL_CLR-1:0];
            end
            if (wr_cmp) begin
                cmp_q <= wdata[CNT_W-1:0];
            end

            // A new match beats a simultaneous write-1-to-clear
            match_q <= match_evt | (match_q & ~(wr_status & wdata[ST_MATCH]));

            if (rd_en) begin
                rdata_q <= rd_mux;
            end

            case (state_q)
                IDLE: begin
                    if (ctrl_q[CTRL_EN]) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (match_evt && ctrl_q[CTRL_ONESHOT]) begin
                        state_q <= FIRED;
                    end
                end
                FIRED: begin
                    if (wr_ctrl && wdata[CTRL_EN]) begin
                        state_q <= ARMED;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Disabling wins over every other transition; a match in this
            // cycle has already been captured in match_q above.
            if (wr_ctrl && !wdata[CTRL_EN]) begin
                state_q <= IDLE;
            end
        end
    end

    assign rdata    = rdata_q;
    assign cnt_zero = cnt_zero_q;
    assign irq      = match_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;
    import counter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  addr = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [31:0] cnt = '0;
    logic        ovf = 1'b0;
    logic        cnt_zero;
    logic        irq;

    // Environment counter controls
    logic        load_req = 1'b0;
    logic [31:0] load_val = '0;
    logic        ovf_set = 1'b0;

    int checks = 0;
    int errors = 0;

    counter_ctrl #(.CNT_W(32), .ADDR_W(2)) dut (
        .clk       (clk),
        .Rst       (rst_n),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .cnt_dout  (cnt),
        .cnt_ovflw (ovf),
        .cnt_zero  (cnt_zero),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Free-running counter with synchronous clear and sticky overflow flag
    always @(posedge clk) begin
        if (load_req) cnt <= load_val;
        else if (cnt_zero === 1'b1) cnt <= '0;
        else cnt <= cnt + 32'd1;
        if (cnt_zero === 1'b1) ovf <= 1'b0;
        else if (ovf_set || cnt == 32'hFFFF_FFFF) ovf <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // snap is the counter value seen by the DUT in the rd_en cycle
    task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic [31:0] snap);
        snap = cnt; addr = a; rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic set_cnt(input logic [31:0] v);
        load_val = v; load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic wait_cnt(input logic [31:0] v, input string tag);
        int k = 0;
        while (cnt !== v && k < 2000) begin
            tick(1);
            k++;
        end
        checks++;
        assert (k < 2000) else begin
            errors++;
            $error("FAIL %s: observed timeout expected cnt %h", tag, v);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, snap, rcmp, prev;
        int n;
        bit w1c, exp_match;

        // Reset held for three edges, then released
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_cz", 32'(cnt_zero), 1);
            check("rst_irq", 32'(irq), 0);
        end
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        tick(1);
        check("rel_cz_hold", 32'(cnt_zero), 1);
        tick(1);
        check("rel_cz_done", 32'(cnt_zero), 0);
        rd(CTRL_A, d, snap);   check("rst_ctrl", d, 0);
        rd(CMP_A, d, snap);    check("rst_cmp", d, 32'hFFFF_FFFF);
        rd(STATUS_A, d, snap); check("rst_status", d, 0);

        // Periodic mode: period CMP+2
        wr(CMP_A, 10);
        wr(CTRL_A, 32'h7);
        set_cnt(0);
        wait_cnt(10, "per_reach");
        tick(1);
        check("per_irq_rise", 32'(irq), 1);
        check("per_cz_first", 32'(cnt_zero), 1);
        for (int p = 0; p < 3; p++) begin
            n = 0;
            for (int i = 1; i <= 12; i++) begin
                tick(1);
                if (i < 12) n += int'(cnt_zero);
            end
            check("per_gap", n, 0);
            check("per_pulse", 32'(cnt_zero), 1);
        end
        tick(1);
        wr(STATUS_A, 32'h1);
        check("per_w1c_irq", 32'(irq), 0);
        wr(CTRL_A, 0);
        wr(STATUS_A, 32'h1);

        // One-shot: one match, then silent until CTRL is rewritten
        wr(CMP_A, 5);
        wr(CTRL_A, 32'hB);
        set_cnt(0);
        n = 0;
        for (int i = 0; i < 30; i++) begin tick(1); n += int'(cnt_zero); end
        check("os_pulses", n, 1);
        rd(STATUS_A, d, snap); check("os_match", d, 1);
        wr(STATUS_A, 32'h1);
        set_cnt(0);
        n = 0;
        for (int i = 0; i < 20; i++) begin tick(1); n += int'(cnt_zero); end
        check("os_fired_pulses", n, 0);
        rd(STATUS_A, d, snap); check("os_fired_status", d, 0);
        wr(CTRL_A, 32'hB);
        set_cnt(0);
        n = 0;
        for (int i = 0; i < 30; i++) begin tick(1); n += int'(cnt_zero); end
        check("os_rearm_pulses", n, 1);
        rd(STATUS_A, d, snap); check("os_rearm_match", d, 1);
        wr(CTRL_A, 0);
        wr(STATUS_A, 32'h1);

        // Collision: W1C of MATCH in the match cycle
        wr(CMP_A, 8);
        wr(CTRL_A, 32'h5);
        set_cnt(0);
        wait_cnt(9, "col_first");
        check("col_irq_pre", 32'(irq), 1);
        set_cnt(0);
        wait_cnt(8, "col_second");
        wr(STATUS_A, 32'h1);
        check("col_irq", 32'(irq), 1);
        rd(STATUS_A, d, snap); check("col_status", d, 1);

        // CLR coinciding with auto-clear gives one pulse
        wr(CTRL_A, 32'h3);
        set_cnt(0);
        wait_cnt(8, "clr_auto_reach");
        wr(CTRL_A, 32'h13);
        check("clr_auto_cz", 32'(cnt_zero), 1);
        tick(1);
        check("clr_auto_single", 32'(cnt_zero), 0);
        check("clr_auto_cnt", cnt, 0);

        // CLR from a large count, readback
        wr(CTRL_A, 0);
        wr(STATUS_A, 32'h1);
        set_cnt(1000);
        tick(2);
        wr(CTRL_A, 32'h10);
        check("clr_cz", 32'(cnt_zero), 1);
        tick(1);
        check("clr_cz_end", 32'(cnt_zero), 0);
        rd(COUNT_A, d, snap);
        check("count_rd", d, snap);
        check("count_le2", 32'(d <= 32'd2), 1);
        rd(CTRL_A, d, snap); check("ctrl_clr_reads0", d, 0);
        wr(CTRL_A, 32'h10);
        check("b2b_cz1", 32'(cnt_zero), 1);
        wr(CTRL_A, 32'h10);
        check("b2b_cz2", 32'(cnt_zero), 1);
        tick(1);
        check("b2b_end", 32'(cnt_zero), 0);
        rd(CMP_A, d, snap); check("cmp_rd", d, 8);
        tick(3);
        check("rdata_hold", rdata, 8);

        // Overflow mirror and clear via STATUS bit 1
        ovf_set = 1'b1;
        tick(1);
        ovf_set = 1'b0;
        rd(STATUS_A, d, snap); check("ovf_status", d, 2);
        wr(STATUS_A, 32'h2);
        check("ovf_cz", 32'(cnt_zero), 1);
        tick(1);
        check("ovf_cz_end", 32'(cnt_zero), 0);
        rd(STATUS_A, d, snap); check("ovf_cleared", d, 0);

        // Randomized periodic runs with random W1C traffic.
        // Rule: a pulse and a MATCH set follow any cycle where the armed
        // counter equals CMP; MATCH otherwise clears on W1C.
        for (int it = 0; it < 4; it++) begin
            rcmp = 32'($urandom_range(3, 30));
            wr(CMP_A, rcmp);
            rd(CMP_A, d, snap); check("rnd_cmp_rd", d, rcmp);
            wr(STATUS_A, 32'h1);
            wr(CTRL_A, 32'h7);
            set_cnt(0);
            exp_match = 1'b0;
            for (int c = 0; c < 3 * (int'(rcmp) + 2) + 5; c++) begin
                prev = cnt;
                w1c = ($urandom_range(0, 7) == 0);
                addr = STATUS_A; wdata = 32'h1; wr_en = w1c;
                @(posedge clk); #1;
                exp_match = (prev == rcmp) | (exp_match & !w1c);
                check("rnd_cz", 32'(cnt_zero), 32'(prev == rcmp));
                check("rnd_irq", 32'(irq), 32'(exp_match));
            end
            wr_en = 1'b0;
            wr(CTRL_A, 0);
            wr(STATUS_A, 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Memory-mapped control and compare stage that sits directly on top of the free-running 32-bit cycle counter. It consumes the counter value and overflow flag and drives the counter's synchronous clear. It adds a compare register with match detection, auto-reload (periodic) and one-shot modes, sticky status, and a level interrupt to the core. The CPU accesses it through the MMIO decode as four 32-bit word registers.

Parameters:
CNT_W, 32, counter/compare width (must equal counter width)
ADDR_W, 2, word-address bits (4 registers)

Ports:
clk  in  1  system clock
Rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
addr  in  ADDR_W  word select: 0 CTRL, 1 CMP, 2 STATUS, 3 COUNT
wr_en  in  1  single-cycle write strobe
rd_en  in  1  single-cycle read strobe
wdata  in  32  write data
rdata  out  32  read data, valid the cycle after rd_en
cnt_dout  in  CNT_W  current counter value
cnt_ovflw  in  1  counter overflow flag (held until counter is cleared)
cnt_zero  out  1  registered clear pulse to the counter
irq  out  1  level interrupt = STATUS.MATCH & CTRL.IRQEN

Behaviour:
- Reset (Rst=0 at clk edge) clears all state: CTRL=0, CMP=0xFFFF_FFFF, STATUS=0, state=IDLE, rdata=0, irq=0. cnt_zero=1 for the reset cycle and the first cycle after Rst returns high, so the counter starts from 0.
- CTRL bits: [0] EN, [1] AUTOCLR, [2] IRQEN, [3] ONESHOT, [4] CLR. CLR is write-only and self-clearing: writing 1 makes cnt_zero=1 for exactly the next cycle. It always reads as 0.
- CMP: read/write. A write while ARMED takes effect for comparisons from the next cycle.
- STATUS: [0] MATCH is sticky and write-1-to-clear. [1] OVF is read-only and mirrors cnt_ovflw. Writing 1 to bit 1 pulses cnt_zero the next cycle.
- COUNT: read-only, returns cnt_dout sampled in the rd_en cycle. Writes are ignored.
- Reads have 1-cycle latency. rdata holds its last value when rd_en=0. Reads have no side effects.
- FSM states:
  - IDLE: entered when EN=0.
  - ARMED: entered from IDLE on the cycle after EN becomes 1.
  - FIRED: one-shot done.
- Transitions:
  - ARMED and cnt_dout==CMP → match event. It sets MATCH at the next edge.
  - On a match with AUTOCLR=1, cnt_zero=1 in the following cycle. The counter shows CMP, CMP+1, then 0, so the period is CMP+2 cycles.
  - On a match with ONESHOT=1, go to FIRED and suppress further matches.
  - FIRED → IDLE on a write with EN=0. FIRED → ARMED on a write of CTRL with EN=1.
  - Any state → IDLE when EN is written 0.
- Match is evaluated only in ARMED, using the registered CTRL/CMP values from before any write in the same cycle.
- Simultaneous events:
  - A match coinciding with a W1C of MATCH: the set wins and MATCH stays 1.
  - A match coinciding with writing EN=0: the match is still recorded, then the FSM goes to IDLE.
  - A CLR coinciding with an auto-clear: a single cnt_zero pulse is issued.
- cnt_zero is one cycle per request. Back-to-back requests give consecutive pulses.
- If the counter wraps without a match, no event occurs. OVF reflects the counter flag until the next cnt_zero.
- Reset mid-operation aborts any pending pulse except the reset-driven clear.

Decomposition:
- Package counter_pkg holds:
  - register index constants (CTRL_A, CMP_A, STATUS_A, COUNT_A)
  - CTRL/STATUS bit positions
  - typedef enum logic [1:0] {IDLE, ARMED, FIRED} cnt_state_t
- Single module, no sub-module. The register file, FSM and pulse generator are each too small to split out.

Test Plan:
- Reset: hold Rst=0 for 3 cycles, then release. Check cnt_zero=1 through the first cycle after release, irq=0, CTRL reads 0, CMP reads 0xFFFF_FFFF.
- Periodic: CMP=10, CTRL=0x7. Check cnt_zero pulses every 12 cycles, irq rises 1 cycle after cnt_dout==10, and W1C STATUS=1 drops irq the next cycle.
- One-shot: CMP=5, CTRL=0xB (EN, AUTOCLR, ONESHOT). Check exactly one match and one cnt_zero, FSM=FIRED, and no MATCH on later passes through 5 until CTRL is rewritten.
- Collision: W1C of MATCH in the same cycle as a new match. Check MATCH reads 1 afterwards and irq stays high.
- CLR and readback: counter at 1000, write CTRL=0x10. Check cnt_zero single pulse, COUNT read 2 cycles later is ≤2, CTRL reads back with bit4=0.
- Overflow: drive cnt_ovflw=1, read STATUS to get 0x2, write STATUS=0x2, check cnt_zero pulses once.
